// File: rtl/spi_pkg.sv
// Shared constants for the SPI datapath: FSM encoding, bit-order flags and the
// mode codes still used by the legacy fixed-width shift registers.
package spi_pkg;

    typedef logic spi_state_t;

    localparam spi_state_t SPI_IDLE  = 1'b0;
    localparam spi_state_t SPI_SHIFT = 1'b1;

    localparam logic SPI_MSB_FIRST = 1'b0;
    localparam logic SPI_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        SPI_MODE_HOLD  = 2'd0,
        SPI_MODE_LEFT  = 2'd1,
        SPI_MODE_RIGHT = 2'd2,
        SPI_MODE_PLOAD = 2'd3
    } spi_mode_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter: cleared at load/abort/frame end, advanced on each accepted
// shift strobe, and flags the final bit position of the frame.
module spi_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic increment,
    output logic last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Saturating at WIDTH-1 keeps non-power-of-two widths from overrunning.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (increment && !last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Parametrised SPI frame shifter: parallel load via valid/ready, serial shift on
// external strobes, and a one-cycle rx_valid pulse when the frame completes.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             lsb_first,
    input  logic             shift_en,
    input  logic             abort,
    input  logic             serialIn,
    output logic             serialOut,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    spi_state_t       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic             in_idle;
    logic             in_shift;
    logic             load;
    logic             shift;
    logic             last;
    logic             frame_done;
    logic             cnt_clear;
    logic [WIDTH-1:0] shifted;

    assign in_idle  = (state_q == SPI_IDLE);
    assign in_shift = (state_q == SPI_SHIFT);

    // Abort dominates both a coincident load and a coincident strobe.
    assign load       = in_idle && tx_valid && !abort;
    assign shift      = in_shift && shift_en && !abort;
    assign frame_done = shift && last;
    assign cnt_clear  = load || (in_shift && abort) || frame_done;

    assign shifted = (order_q == SPI_LSB_FIRST) ? {serialIn, sreg_q[WIDTH-1:1]}
                                                : {sreg_q[WIDTH-2:0], serialIn};

    spi_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .increment (shift),
        .last      (last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SPI_IDLE: begin
                if (load) begin
                    state_d = SPI_SHIFT;
                end
            end
            SPI_SHIFT: begin
                if (abort || (shift_en && last)) begin
                    state_d = SPI_IDLE;
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    // FSM outputs; serialOut is forced low outside a frame.
    always_comb begin
        tx_ready  = 1'b0;
        busy      = 1'b0;
        serialOut = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                tx_ready = 1'b1;
            end
            SPI_SHIFT: begin
                busy      = 1'b1;
                serialOut = (order_q == SPI_LSB_FIRST) ? sreg_q[0] : sreg_q[WIDTH-1];
            end
            default: begin
                tx_ready = 1'b1;
            end
        endcase
    end

    // Shift datapath and receive capture.
    always_comb begin
        sreg_d     = sreg_q;
        order_d    = order_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (load) begin
            sreg_d  = tx_data;
            order_d = lsb_first;
        end else if (shift) begin
            sreg_d = shifted;
            if (frame_done) begin
                rx_data_d  = shifted;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q     <= '0;
            order_q    <= SPI_MSB_FIRST;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            order_q    <= order_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised SPI frame shifter that supersedes the fixed 8/9-bit shift registers in the memory/SPI datapath. It accepts a parallel word through a valid/ready handshake, shifts it out serially while capturing serial input on externally supplied sample strobes, and counts bits to frame-complete. The received word is then presented with a one-cycle valid pulse. It sits between the SPI input conditioner (which supplies the `shift_en` strobe) and the register-file/address-latch logic.

## Interface
- `WIDTH`, 8: frame length in bits; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  WIDTH  word to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  engine can accept a word (IDLE).
- `lsb_first`  in  1  bit order: 0 = MSB first, 1 = LSB first; captured at load.
- `shift_en`  in  1  single-cycle shift strobe (the conditioned SPI clock edge).
- `abort`  in  1  synchronous frame abort (e.g. chip-select deasserted).
- `serialIn`  in  1  serial data in (sampled on `shift_en`).
- `serialOut`  out  1  serial data out.
- `rx_data`  out  WIDTH  last completed received word.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` just updated.
- `busy`  out  1  high while in SHIFT.

## Operation
- States: IDLE, SHIFT.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, order flag = 0, `rx_data` = 0, `rx_valid` = 0. Resulting outputs: `tx_ready` = 1, `busy` = 0, `serialOut` = 0.
- IDLE:
  - `tx_ready` = 1 and `serialOut` = 0; `shift_en` is ignored.
  - `tx_valid` && `tx_ready` loads `tx_data` into the shift register, latches `lsb_first` into the order flag, clears the counter and enters SHIFT.
- SHIFT:
  - `serialOut` = reg[WIDTH-1] when MSB-first, reg[0] when LSB-first (combinational from the register).
  - Each `shift_en` shifts the register and increments the counter:
    - MSB-first: reg <= {reg[WIDTH-2:0], serialIn}.
    - LSB-first: reg <= {serialIn, reg[WIDTH-1:1]}.
  - On the `shift_en` with counter = WIDTH-1 (the final bit): `rx_data` <= shifted value, `rx_valid` <= 1, state <= IDLE.
  - Cycles without `shift_en` hold all state.
- `abort` in SHIFT: state <= IDLE and counter <= 0. There is no `rx_valid` and `rx_data` is unchanged. `abort` wins over a coincident `shift_en`, including on the final bit. `abort` in IDLE has no effect, and a coincident load is suppressed.
- Changes to `lsb_first` or `tx_data` during SHIFT are ignored.
- Counter width is `$clog2(WIDTH)`. It never exceeds WIDTH-1 and cannot wrap.
- `rst_n` low at any time, including mid-frame, forces all reset values immediately. No `rx_valid` is produced for the interrupted frame.

## Timing
- Load latency: handshake at edge N means `busy` = 1 and first-bit `serialOut` are valid from cycle N+1.
- Strobes: `shift_en` may arrive at the earliest in the cycle after load, with any spacing down to back-to-back cycles.
- Completion: the final `shift_en` in cycle C gives `rx_valid` = 1, `busy` = 0 and `tx_ready` = 1 in cycle C+1. `rx_valid` deasserts in C+2 unconditionally; there is no backpressure.
- Back-to-back frames: a new load is accepted in C+1, concurrent with `rx_valid`, so the minimum `busy` gap is exactly one cycle.
- Abort: `abort` in cycle A gives `tx_ready` = 1 in A+1.

## Structure
- Shared package `spi_pkg`:
  - state encoding localparams `SPI_IDLE` = 1'b0 and `SPI_SHIFT` = 1'b1;
  - bit-order constants `SPI_MSB_FIRST` = 0 and `SPI_LSB_FIRST` = 1.
  - The existing HOLD/LEFT/RIGHT/PLOAD mode defines remain for the legacy registers.
- One sub-module, `spi_bit_counter`:
  - parameter `WIDTH`; inputs clear and increment; output `last` (count == WIDTH-1);
  - asynchronous active-low reset.
- FSM, shift datapath and rx capture stay in the top level.

## Test plan
- Reset: assert `rst_n` = 0 for 3 cycles with random inputs → `tx_ready` = 1, `busy` = 0, `rx_valid` = 0, `serialOut` = 0, `rx_data` = 0.
- MSB-first loopback (WIDTH = 8): load 0xA5, tie `serialIn` = `serialOut`, 8 strobes spaced 3 cycles apart → `serialOut` = 1,0,1,0,0,1,0,1; `rx_valid` pulses one cycle after the 8th strobe with `rx_data` = 0xA5.
- LSB-first: load 0x01 with `lsb_first` = 1 and `serialIn` = 1 constant → `serialOut` = 1,0,0,0,0,0,0,0; `rx_data` = 0xFF. Toggling `lsb_first` mid-frame has no effect.
- Abort: load 0x3C, issue 3 strobes, then `abort` together with `shift_en` → IDLE next cycle, no `rx_valid`, `rx_data` keeps its prior value. A subsequent frame works normally.
- Back-to-back: hold `tx_valid` = 1 with 0x11 then 0x22 and continuous strobes → second load in the `rx_valid` cycle, `busy` low for exactly 1 cycle, `rx_data` sequence 0x11 then 0x22 under loopback.
- Reset mid-frame and WIDTH = 9:
  - Drop `rst_n` after 5 strobes → outputs reset asynchronously, before the next clock edge, with no `rx_valid`.
  - Rerun the loopback with WIDTH = 9 and word 0x1A5 → `rx_data` = 0x1A5.
